// File: rtl/cpu5_mcycle_datapath_if.sv
// Bus between the multi-cycle datapath, its instruction decoder and the
// single shared memory port. The datapath is the master side.
interface cpu5_mcycle_datapath_if #(
  parameter int XLEN = 32
);
  // decoder control lines, derived by the decoder from instr
  logic            memtoreg;
  logic            memwrite;
  logic            alusrc;
  logic            regwrite;
  logic            jump;
  logic [2:0]      branchtype;
  logic [3:0]      alucontrol;
  logic [2:0]      immtype;

  // architectural state visible to the decoder / debug
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;

  // shared memory port, a transfer completes when mem_req && mem_ready
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  logic            retire;

  modport master (
    input  memtoreg, memwrite, alusrc, regwrite, jump,
    input  branchtype, alucontrol, immtype,
    input  mem_rdata, mem_ready,
    output instr, pc,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output retire
  );

  modport slave (
    output memtoreg, memwrite, alusrc, regwrite, jump,
    output branchtype, alucontrol, immtype,
    output mem_rdata, mem_ready,
    input  instr, pc,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  retire
  );
endinterface

// File: rtl/cpu5_mcycle_datapath.sv
// Multi-cycle RV-style datapath: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// One instruction in flight; instruction fetch and data access share one
// memory port. Immediate extraction assumes XLEN >= 32.
module cpu5_mcycle_datapath #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              RFIDX_WIDTH = 5
) (
  input logic                    clk,
  input logic                    reset,
  cpu5_mcycle_datapath_if.master bus
);
  localparam int NREGS = 2 ** RFIDX_WIDTH;
  localparam int SHW   = $clog2(XLEN);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_LT   = 3'd3;
  localparam logic [2:0] BR_GE   = 3'd4;
  localparam logic [2:0] BR_LTU  = 3'd5;
  localparam logic [2:0] BR_GEU  = 3'd6;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  logic [2:0]             state;
  logic [XLEN-1:0]        pc_reg;
  logic [XLEN-1:0]        ir;
  logic [XLEN-1:0]        a_reg;
  logic [XLEN-1:0]        b_reg;
  logic [XLEN-1:0]        imm_reg;
  logic [XLEN-1:0]        aluout;
  logic [XLEN-1:0]        mdr;
  logic                   zero;
  logic [XLEN-1:0]        rf [NREGS];

  logic [RFIDX_WIDTH-1:0] rs1;
  logic [RFIDX_WIDTH-1:0] rs2;
  logic [RFIDX_WIDTH-1:0] rd;
  logic signed [31:0]     imm32;
  logic [XLEN-1:0]        imm_ext;
  logic [XLEN-1:0]        opb;
  logic [SHW-1:0]         shamt;
  logic [XLEN-1:0]        alu_result;
  logic [XLEN-1:0]        pc_plus4;
  logic [XLEN-1:0]        wb_data;
  logic                   taken;

  assign rs1      = ir[15 +: RFIDX_WIDTH];
  assign rs2      = ir[20 +: RFIDX_WIDTH];
  assign rd       = ir[7 +: RFIDX_WIDTH];
  assign pc_plus4 = pc_reg + XLEN'(4);
  assign opb      = bus.alusrc ? imm_reg : b_reg;
  assign shamt    = opb[SHW-1:0];
  assign imm_ext  = XLEN'(imm32);

  // Immediate extraction; the B form is the halfword offset, scaled at use
  always_comb begin
    imm32 = '0;
    case (bus.immtype)
      IMM_I:   imm32 = {{20{ir[31]}}, ir[31:20]};
      IMM_S:   imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm32 = {{20{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8]};
      IMM_U:   imm32 = {ir[31:12], 12'b0};
      IMM_J:   imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // ALU on the latched operands
  always_comb begin
    alu_result = '0;
    case (bus.alucontrol)
      ALU_ADD:   alu_result = a_reg + opb;
      ALU_SUB:   alu_result = a_reg - opb;
      ALU_AND:   alu_result = a_reg & opb;
      ALU_OR:    alu_result = a_reg | opb;
      ALU_XOR:   alu_result = a_reg ^ opb;
      ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(a_reg) < $signed(opb))};
      ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (a_reg < opb)};
      ALU_SLL:   alu_result = a_reg << shamt;
      ALU_SRL:   alu_result = a_reg >> shamt;
      ALU_SRA:   alu_result = $unsigned($signed(a_reg) >>> shamt);
      ALU_PASSB: alu_result = opb;
      default:   alu_result = '0;
    endcase
  end

  // Branch decision compares the two register operands directly
  always_comb begin
    taken = 1'b0;
    case (bus.branchtype)
      BR_EQ:   taken = (a_reg == b_reg);
      BR_NE:   taken = (a_reg != b_reg);
      BR_LT:   taken = ($signed(a_reg) < $signed(b_reg));
      BR_GE:   taken = ($signed(a_reg) >= $signed(b_reg));
      BR_LTU:  taken = (a_reg < b_reg);
      BR_GEU:  taken = (a_reg >= b_reg);
      default: taken = 1'b0;
    endcase
  end

  // Write-back source: link address, loaded data or ALU result
  always_comb begin
    wb_data = aluout;
    if (bus.jump) begin
      wb_data = pc_plus4;
    end else if (bus.memtoreg) begin
      wb_data = mdr;
    end
  end

  assign bus.instr     = ir;
  assign bus.pc        = pc_reg;
  assign bus.mem_req   = (state == S_FETCH) || (state == S_MEM);
  assign bus.mem_we    = (state == S_MEM) && bus.memwrite;
  assign bus.mem_addr  = (state == S_MEM) ? aluout : pc_reg;
  assign bus.mem_wdata = b_reg;
  assign bus.retire    = ((state == S_EXEC) && (bus.branchtype != BR_NONE)) ||
                         ((state == S_MEM) && bus.memwrite && bus.mem_ready) ||
                         (state == S_WB);

  // Main sequencer and datapath registers; each register moves only in its own state
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc_reg  <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      imm_reg <= '0;
      aluout  <= '0;
      mdr     <= '0;
      zero    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            ir    <= bus.mem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg   <= rf[rs1];
          b_reg   <= rf[rs2];
          imm_reg <= imm_ext;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          aluout <= alu_result;
          zero   <= (alu_result == '0);
          if (bus.branchtype != BR_NONE) begin
            pc_reg <= taken ? (pc_reg + (imm_reg << 1)) : pc_plus4;
            state  <= S_FETCH;
          end else if (bus.memtoreg || bus.memwrite) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (bus.memwrite) begin
              pc_reg <= pc_plus4;
              state  <= S_FETCH;
            end else begin
              mdr   <= bus.mem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          pc_reg <= bus.jump ? aluout : pc_plus4;
          state  <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Register file; x0 is never written so it always reads zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if ((state == S_WB) && bus.regwrite && (rd != '0)) begin
      rf[rd] <= wb_data;
    end
  end
endmodule

// File: doc/cpu5_mcycle_datapath.md
CPU5_MCYCLE_DATAPATH -- requirements
Module: cpu5_mcycle_datapath

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath, register and address width.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter RFIDX_WIDTH, default 5: register index width (32 registers).
REQ-004 clk  in  1: single clock; all state updates on rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 Control inputs from the decoder: memtoreg, memwrite, alusrc, regwrite, jump (1 each); branchtype, alucontrol, immtype (codebase widths).
REQ-007 instr  out  XLEN: current instruction register (IR), which drives the decoder.
REQ-008 pc  out  XLEN: current PC register.
REQ-009 mem_req  out  1: memory request valid.
REQ-010 mem_we  out  1: request is a store.
REQ-011 mem_addr, mem_wdata  out  XLEN: request address and store data.
REQ-012 mem_rdata  in  XLEN; mem_ready  in  1: response data and completion; a transfer completes in a cycle with mem_req and mem_ready both high.
REQ-013 retire  out  1: one-cycle pulse when an instruction completes.

Function
REQ-014 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, one instruction at a time through one shared memory port.
REQ-015 FETCH: mem_req=1, mem_we=0, mem_addr=pc; hold until mem_ready; on completion IR<=mem_rdata, go to DECODE.
REQ-016 DECODE: latch A<=rf[rs1], B<=rf[rs2], immediate from immtype; go to EXEC (always 1 cycle).
REQ-017 EXEC: ALU operand B = alusrc ? imm : B; latch ALUOUT and zero.
REQ-018 EXEC with branchtype not NONE: pc <= taken ? pc+(imm<<1) : pc+4; retire=1; go to FETCH; no register write.
REQ-019 EXEC with memtoreg or memwrite: go to MEM; otherwise go to WB.
REQ-020 MEM: mem_req=1, mem_addr=ALUOUT, mem_we=memwrite, mem_wdata=B; hold all outputs stable until mem_ready.
REQ-021 MEM completion for a load: MDR<=mem_rdata, go to WB.
REQ-022 MEM completion for a store: pc<=pc+4, retire=1, go to FETCH.
REQ-023 WB: if regwrite and rd!=0, rf[rd] <= jump ? pc+4 : (memtoreg ? MDR : ALUOUT).
REQ-024 WB: pc <= jump ? ALUOUT : pc+4; retire=1; go to FETCH.
REQ-025 Writes to x0 SHALL be discarded; x0 always reads 0.
REQ-026 All PC arithmetic SHALL be modulo 2^XLEN (wraps, no trap).
REQ-027 mem_req SHALL be 0 in DECODE, EXEC and WB.
REQ-028 IR, pc, A, B, ALUOUT, MDR SHALL change only in the states listed above.
REQ-029 Latency with zero wait states: branch 3 cycles, store 4, ALU/jump 4, load 5; each wait cycle adds 1.

Reset
REQ-030 reset SHALL have priority over all transitions, including in the middle of FETCH or MEM with mem_ready low.
REQ-031 On reset: state=FETCH, pc=RESET_PC, IR=0, A=B=ALUOUT=MDR=0, all registers 0.
REQ-032 In the first cycle after reset: mem_req=1, mem_addr=RESET_PC, mem_we=0, retire=0.
REQ-033 After a reset during MEM, a store SHALL NOT be reissued.

Verification
REQ-034 Reset release with RESET_PC=0x100: next cycle mem_req=1, mem_addr=0x100, retire=0.
REQ-035 Issue add x3,x1,x2 with x1=5, x2=7 and mem_ready always 1: retire at cycle 4, x3=12, pc=0x104.
REQ-036 Issue lw x4,8(x1) with x1=0x200 and 2 wait states in MEM: mem_addr=0x208 held 3 cycles, x4=mem_rdata, retire at cycle 7.
REQ-037 Issue beq taken with imm field giving offset 0x10 at pc=0x40: pc=0x50 after 3 cycles, no register written; repeat not-taken: pc=0x44.
REQ-038 Issue a jump with rd=1 at pc=0x80 and ALUOUT=0x300: x1=0x84, pc=0x300; repeat with rd=0: x0 stays 0.
REQ-039 Issue a store and assert reset during MEM with mem_ready=0: next cycle state=FETCH, pc=RESET_PC, mem_we=0, no store completes.
